// File: rtl/dual_port_sync_ram_if.sv
// Bus bundle for dual_port_sync_ram: write port, read port and status.
interface dual_port_sync_ram_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                      w_cs;
   logic [ADDR_WIDTH-1:0]     w_addr;
   logic [DATA_WIDTH-1:0]     w_data;
   logic [DATA_WIDTH/8-1:0]   w_be;
   logic                      r_cs;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [DATA_WIDTH-1:0]     r_data;
   logic                      r_valid;
   logic                      busy;

   modport master (
      output w_cs, w_addr, w_data, w_be, r_cs, r_addr,
      input  r_data, r_valid, busy
   );

   modport slave (
      input  w_cs, w_addr, w_data, w_be, r_cs, r_addr,
      output r_data, r_valid, busy
   );
endinterface

// File: rtl/dual_port_sync_ram.sv
// One-write/one-read synchronous RAM with byte enables and a post-reset zero clear.
// Optional macro DUAL_PORT_SYNC_RAM_OUT_REG_EN adds an output register stage (read latency 2).
module dual_port_sync_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dual_port_sync_ram_if.slave  bus
);

   localparam int unsigned           NUM_LANES = DATA_WIDTH / 8;
   localparam int unsigned           CMP_W     = ADDR_WIDTH + 1;
   localparam logic [CMP_W-1:0]      DEPTH_LIM = CMP_W'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  busy_q, busy_d;
   logic                  clr_we_c;
   logic                  wr_accept_c;
   logic                  rd_accept_c;
   logic                  w_in_range_c;
   logic                  r_in_range_c;
   logic                  collide_c;
   logic [DATA_WIDTH-1:0] rd_word_c;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic                  r_valid_q;

   assign w_in_range_c = {1'b0, bus.w_addr} < DEPTH_LIM;
   assign r_in_range_c = {1'b0, bus.r_addr} < DEPTH_LIM;
   assign collide_c    = wr_accept_c && (bus.w_addr == bus.r_addr);

   // FSM state, clear counter and busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Next state and request qualification
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      busy_d      = busy_q;
      clr_we_c    = 1'b0;
      wr_accept_c = 1'b0;
      rd_accept_c = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we_c  = 1'b1;
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = ST_READY;
               busy_d    = 1'b0;
               clr_cnt_d = '0;
            end
         end
         ST_READY: begin
            wr_accept_c = bus.w_cs && w_in_range_c;
            rd_accept_c = bus.r_cs;
         end
         default: begin
            state_d = ST_CLEAR;
            busy_d  = 1'b1;
         end
      endcase
   end

   // Storage: the clear sweep has priority; user writes are per byte lane
   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         mem[clr_cnt_q] <= '0;
      end else if (wr_accept_c) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.w_be[i]) mem[bus.w_addr][i*8 +: 8] <= bus.w_data[i*8 +: 8];
         end
      end
   end

   // Read word with write-first forwarding on enabled lanes; out-of-range reads give zero
   always_comb begin
      rd_word_c = '0;
      if (r_in_range_c) begin
         rd_word_c = mem[bus.r_addr];
         if (collide_c) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (bus.w_be[i]) rd_word_c[i*8 +: 8] = bus.w_data[i*8 +: 8];
            end
         end
      end
   end

`ifdef DUAL_PORT_SYNC_RAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] p1_data_q;
   logic                  p1_valid_q;

   // Two-stage read pipeline, one valid bit per stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_data_q  <= '0;
         p1_valid_q <= 1'b0;
         r_data_q   <= '0;
         r_valid_q  <= 1'b0;
      end else begin
         p1_valid_q <= rd_accept_c;
         if (rd_accept_c) p1_data_q <= rd_word_c;
         r_valid_q  <= p1_valid_q;
         if (p1_valid_q) r_data_q <= p1_data_q;
      end
   end
`else
   // Single-stage read register; data holds when no read completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= rd_accept_c;
         if (rd_accept_c) r_data_q <= rd_word_c;
      end
   end
`endif

   assign bus.r_data  = r_data_q;
   assign bus.r_valid = r_valid_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Directed bench for dual_port_sync_ram: a DEPTH=16 instance and a DEPTH=12 instance.
module tb_dual_port_sync_ram;

`ifdef DUAL_PORT_SYNC_RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   dual_port_sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus16 ();
   dual_port_sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus12 ();

   dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12)) dut12 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr16(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      bus16.w_cs = 1'b1; bus16.w_addr = a; bus16.w_data = d; bus16.w_be = be;
      tick();
      bus16.w_cs = 1'b0;
   endtask

   task automatic wr12(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      bus12.w_cs = 1'b1; bus12.w_addr = a; bus12.w_data = d; bus12.w_be = be;
      tick();
      bus12.w_cs = 1'b0;
   endtask

   task automatic rd16(input logic [3:0] a, input logic [15:0] exp, input string tag);
      bus16.r_cs = 1'b1; bus16.r_addr = a;
      tick();
      bus16.r_cs = 1'b0;
      repeat (LAT - 1) tick();
      check({tag, "_valid"}, {31'd0, bus16.r_valid}, 32'd1);
      check(tag, {16'd0, bus16.r_data}, {16'd0, exp});
   endtask

   task automatic rd12(input logic [3:0] a, input logic [15:0] exp, input string tag);
      bus12.r_cs = 1'b1; bus12.r_addr = a;
      tick();
      bus12.r_cs = 1'b0;
      repeat (LAT - 1) tick();
      check({tag, "_valid"}, {31'd0, bus12.r_valid}, 32'd1);
      check(tag, {16'd0, bus12.r_data}, {16'd0, exp});
   endtask

   // Counts sampled cycles with busy high, bounded so a stuck busy still terminates
   task automatic count_busy16(output int n, output bit saw_valid);
      n = 0;
      saw_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (!bus16.busy) break;
         n++;
         if (bus16.r_valid) saw_valid = 1'b1;
         tick();
      end
   endtask

   int n_busy;
   bit saw_v;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus16.w_cs = 1'b0; bus16.w_addr = '0; bus16.w_data = '0; bus16.w_be = '0;
      bus16.r_cs = 1'b0; bus16.r_addr = '0;
      bus12.w_cs = 1'b0; bus12.w_addr = '0; bus12.w_data = '0; bus12.w_be = '0;
      bus12.r_cs = 1'b0; bus12.r_addr = '0;
      tick();
      tick();

      check("rst_r_valid", {31'd0, bus16.r_valid}, 32'd0);
      check("rst_r_data",  {16'd0, bus16.r_data},  32'd0);
      check("rst_busy",    {31'd0, bus16.busy},    32'd1);
      check("rst_busy12",  {31'd0, bus12.busy},    32'd1);

      // Release reset with a read request held on address 3
      rst_n = 1'b1;
      bus16.r_cs = 1'b1; bus16.r_addr = 4'd3;
      count_busy16(n_busy, saw_v);
      check("busy_cycles", 32'(n_busy), 32'd16);
      check("no_valid_while_busy", {31'd0, saw_v}, 32'd0);
      repeat (LAT) tick();
      check("first_rd_valid", {31'd0, bus16.r_valid}, 32'd1);
      check("first_rd_data",  {16'd0, bus16.r_data},  32'h0000);
      bus16.r_cs = 1'b0;
      repeat (LAT + 1) tick();
      check("idle_valid", {31'd0, bus16.r_valid}, 32'd0);
      check("busy12_done", {31'd0, bus12.busy}, 32'd0);

      // Byte-lane partial write
      wr16(4'd5, 16'hA5C3, 2'b11);
      wr16(4'd5, 16'hFF00, 2'b01);
      rd16(4'd5, 16'hA500, "be_partial");

      // Same-edge collision, write-first per lane
      wr16(4'd7, 16'hBEEF, 2'b11);
      bus16.w_cs = 1'b1; bus16.w_addr = 4'd7; bus16.w_data = 16'h1234; bus16.w_be = 2'b10;
      bus16.r_cs = 1'b1; bus16.r_addr = 4'd7;
      tick();
      bus16.w_cs = 1'b0; bus16.r_cs = 1'b0;
      repeat (LAT - 1) tick();
      check("collide_valid", {31'd0, bus16.r_valid}, 32'd1);
      check("collide_data",  {16'd0, bus16.r_data},  32'h12EF);
      rd16(4'd7, 16'h12EF, "collide_stored");

      // All-zero byte enables leave the word unchanged
      wr16(4'd7, 16'hFFFF, 2'b00);
      rd16(4'd7, 16'h12EF, "be_zero");

      // Read and write to different addresses on the same edge
      bus16.w_cs = 1'b1; bus16.w_addr = 4'd8; bus16.w_data = 16'h8888; bus16.w_be = 2'b11;
      bus16.r_cs = 1'b1; bus16.r_addr = 4'd5;
      tick();
      bus16.w_cs = 1'b0; bus16.r_cs = 1'b0;
      repeat (LAT - 1) tick();
      check("indep_rd_data", {16'd0, bus16.r_data}, 32'hA500);
      rd16(4'd8, 16'h8888, "indep_wr");

      // Back-to-back reads of addresses 0..3
      for (int a = 0; a < 4; a++) wr16(4'(a), 16'((a + 1) * 16'h0011), 2'b11);
      for (int i = 0; i < 4 + LAT - 1; i++) begin
         if (i < 4) begin
            bus16.r_cs = 1'b1; bus16.r_addr = 4'(i);
         end else begin
            bus16.r_cs = 1'b0;
         end
         tick();
         if (i >= LAT - 1) begin
            check($sformatf("b2b_valid%0d", i - (LAT - 1)), {31'd0, bus16.r_valid}, 32'd1);
            check($sformatf("b2b_data%0d", i - (LAT - 1)), {16'd0, bus16.r_data},
                  32'((i - (LAT - 1) + 1) * 32'h11));
         end
      end
      bus16.r_cs = 1'b0;
      tick();
      check("hold_valid", {31'd0, bus16.r_valid}, 32'd0);
      check("hold_data",  {16'd0, bus16.r_data},  32'h0044);

      // Out-of-range access on the DEPTH=12 instance
      wr12(4'd1,  16'h1111, 2'b11);
      wr12(4'd13, 16'h5555, 2'b11);
      rd12(4'd13, 16'h0000, "oor_read");
      for (int a = 0; a < 12; a++)
         rd12(4'(a), (a == 1) ? 16'h1111 : 16'h0000, $sformatf("oor_keep%0d", a));

      // Reset between read acceptance and completion
      wr16(4'd9, 16'h9999, 2'b11);
      bus16.r_cs = 1'b1; bus16.r_addr = 4'd9;
      tick();
      bus16.r_cs = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, bus16.r_valid}, 32'd0);
      check("midrst_data",  {16'd0, bus16.r_data},  32'd0);
      check("midrst_busy",  {31'd0, bus16.busy},    32'd1);
      tick();
      rst_n = 1'b1;
      count_busy16(n_busy, saw_v);
      check("reclear_cycles", 32'(n_busy), 32'd16);
      check("reclear_no_valid", {31'd0, saw_v}, 32'd0);
      rd16(4'd9, 16'h0000, "reclear_a9");
      rd16(4'd5, 16'h0000, "reclear_a5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
